// File: rtl/loader_pkg.sv
// Shared types and helpers for the program-memory loader.
// LOADER_CHECKSUM_EN adds the CHK state used by the optional frame checksum.
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      LD_IDLE   = 3'd0,
      LD_LEN0   = 3'd1,
      LD_LEN1   = 3'd2,
      LD_DATA   = 3'd3,
      LD_WRITE  = 3'd4,
      LD_FINISH = 3'd5,
      LD_ERR    = 3'd6
`ifdef LOADER_CHECKSUM_EN
      ,
      LD_CHK    = 3'd7
`endif
   } loader_state_e;

   function automatic logic [17:0] words_to_bytes(input logic [15:0] words);
      return {words, 2'b00};
   endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-stream input, Program_Mem write port and core control of the loader.
// master = loader side, slave = the stream source / memory / core side.
interface prog_mem_loader_if #(
   parameter int ADDR_W = 14
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              core_clk_en;
   logic              core_rstB;
   logic              load_done;
   logic              load_err;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, mem_we, mem_addr, mem_din,
             core_clk_en, core_rstB, load_done, load_err
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, mem_we, mem_addr, mem_din,
             core_clk_en, core_rstB, load_done, load_err
   );
endinterface

// File: rtl/word_assembler.sv
// Shifts bytes in LSB first to build a little-endian 32-bit word.
// full marks that the fourth byte has landed; it drops on the next shift or clear.
module word_assembler (
   input  logic        clk,
   input  logic        rstB,
   input  logic        shift_en,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   output logic [1:0]  byte_cnt,
   output logic [31:0] word,
   output logic        full
);

   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         byte_cnt <= 2'd0;
         word     <= 32'd0;
         full     <= 1'b0;
      end else if (clear) begin
         byte_cnt <= 2'd0;
         word     <= 32'd0;
         full     <= 1'b0;
      end else if (shift_en) begin
         // newest byte enters at the top, so the first byte ends in bits [7:0]
         word     <= {byte_in, word[31:8]};
         byte_cnt <= byte_cnt + 2'd1;
         full     <= (byte_cnt == 2'd3);
      end
   end

endmodule

// File: rtl/prog_mem_loader.sv
// Loads a framed byte stream into Program_Mem and holds the core while loading.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 data checksum byte.
//
// state  | meaning
// IDLE   | waiting for SYNC_BYTE, other bytes dropped
// LEN0   | expecting word count low byte
// LEN1   | expecting word count high byte, range check
// DATA   | collecting the four bytes of the next word
// WRITE  | one-cycle Program_Mem write of the assembled word
// CHK    | expecting checksum byte (LOADER_CHECKSUM_EN only)
// FINISH | load_done pulse, core released on the next edge
// ERR    | bad frame, core held, waiting for SYNC_BYTE
module prog_mem_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W        = 14,
   parameter int         MAX_WORDS     = 4096,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
   parameter bit         HOLD_AT_RESET = 1'b1
) (
   input  logic clk,
   input  logic rstB,
   prog_mem_loader_if.master bus
);

   localparam logic [2:0] S_IDLE   = LD_IDLE;
   localparam logic [2:0] S_LEN0   = LD_LEN0;
   localparam logic [2:0] S_LEN1   = LD_LEN1;
   localparam logic [2:0] S_DATA   = LD_DATA;
   localparam logic [2:0] S_WRITE  = LD_WRITE;
   localparam logic [2:0] S_FINISH = LD_FINISH;
   localparam logic [2:0] S_ERR    = LD_ERR;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK    = LD_CHK;
   localparam logic [2:0] S_AFTER_DATA = S_CHK;
`else
   localparam logic [2:0] S_AFTER_DATA = S_FINISH;
`endif

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   logic [2:0]  state;
   logic [7:0]  len_lo;
   logic [15:0] n_words;
   logic [15:0] word_cnt;
   logic        core_run;
   logic        load_err;

   logic        rx_ready;
   logic        accept;
   logic [15:0] n_rx;
   logic        last_word;
   logic        is_sync;

   logic        asm_shift;
   logic        asm_clear;
   logic [1:0]  asm_cnt;
   logic [31:0] asm_word;
   logic        asm_full;

   assign rx_ready  = (state != S_WRITE) && (state != S_FINISH);
   assign accept    = bus.rx_valid && rx_ready;
   assign n_rx      = {bus.rx_data, len_lo};
   assign last_word = (word_cnt == n_words - 16'd1);
   assign is_sync   = (bus.rx_data == SYNC_BYTE);

   assign asm_shift = accept && (state == S_DATA);
   assign asm_clear = accept && (state == S_LEN1);

   word_assembler u_asm (
      .clk      (clk),
      .rstB     (rstB),
      .shift_en (asm_shift),
      .clear    (asm_clear),
      .byte_in  (bus.rx_data),
      .byte_cnt (asm_cnt),
      .word     (asm_word),
      .full     (asm_full)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         csum <= 8'd0;
      end else if (asm_clear) begin
         csum <= 8'd0;
      end else if (asm_shift) begin
         csum <= csum + bus.rx_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstB) begin
      if (!rstB) begin
         state    <= S_IDLE;
         len_lo   <= 8'd0;
         n_words  <= 16'd0;
         word_cnt <= 16'd0;
         core_run <= !HOLD_AT_RESET;
         load_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_ERR: begin
               if (accept && is_sync) begin
                  state    <= S_LEN0;
                  core_run <= 1'b0;
                  load_err <= 1'b0;
               end
            end
            S_LEN0: begin
               if (accept) begin
                  len_lo <= bus.rx_data;
                  state  <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (accept) begin
                  n_words  <= n_rx;
                  word_cnt <= 16'd0;
                  if (n_rx == 16'd0) begin
                     state <= S_FINISH;
                  end else if (n_rx > MAX_N) begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept && (asm_cnt == 2'd3)) begin
                  state <= S_WRITE;
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt + 16'd1;
               state    <= last_word ? S_AFTER_DATA : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  if (bus.rx_data == csum) begin
                     state <= S_FINISH;
                  end else begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
            end
`endif
            S_FINISH: begin
               core_run <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // address follows the word counter; the post-final-write wrap is never used for a write
   assign bus.mem_addr    = ADDR_W'(words_to_bytes(word_cnt));
   assign bus.mem_din     = asm_word;
   assign bus.mem_we      = (state == S_WRITE) && asm_full;
   assign bus.rx_ready    = rx_ready;
   assign bus.load_done   = (state == S_FINISH);
   assign bus.load_err    = load_err;
   assign bus.core_clk_en = core_run;
   assign bus.core_rstB   = core_run;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: frame-level reference model feeds
// expected writes/outcomes into queues, a negedge monitor pops and compares.
module tb_prog_mem_loader;
   import loader_pkg::*;

   localparam int         ADDR_W    = 14;
   localparam int         MAX_WORDS = 4096;
   localparam logic [7:0] SYNC      = 8'hA5;
   localparam int         EV_DONE   = 1;
   localparam int         EV_ERR    = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk  = 1'b0;
   logic rstB = 1'b0;

   prog_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   prog_mem_loader #(
      .ADDR_W        (ADDR_W),
      .MAX_WORDS     (MAX_WORDS),
      .SYNC_BYTE     (SYNC),
      .HOLD_AT_RESET (1'b1)
   ) dut (
      .clk  (clk),
      .rstB (rstB),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   wr_t         exp_wr[$];
   int          exp_ev[$];
   logic [7:0]  frm[$];
   logic [31:0] wq[$];
   int          tests = 0;
   int          fails = 0;
   logic        chk_release = 1'b0;
   logic        prev_err = 1'b0;
   wr_t         mon_w;
   int          mon_ev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_event(input string name, input int want);
      if (exp_ev.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: got event %0d, expected no event (t=%0t)", name, want, $time);
      end else begin
         mon_ev = exp_ev.pop_front();
         check(name, 64'(want), 64'(mon_ev));
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rstB) begin
         check("rx_ready_only_low_in_write_finish", 64'(bus.rx_ready),
               64'(!(bus.mem_we || bus.load_done)));
         if (chk_release) begin
            check("core_rstB_released", 64'(bus.core_rstB), 64'd1);
            check("core_clk_en_released", 64'(bus.core_clk_en), 64'd1);
            chk_release = 1'b0;
         end
         if (bus.mem_we) begin
            if (exp_wr.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0h din %0h, expected no write",
                        bus.mem_addr, bus.mem_din);
            end else begin
               mon_w = exp_wr.pop_front();
               check("mem_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
               check("mem_din", 64'(bus.mem_din), 64'(mon_w.data));
               check("core_held_in_write", 64'(bus.core_rstB), 64'd0);
            end
         end
         if (bus.load_done) begin
            pop_event("load_done_event", EV_DONE);
            check("core_held_at_done", 64'(bus.core_rstB), 64'd0);
            chk_release = 1'b1;
         end
         if (bus.load_err && !prev_err) begin
            pop_event("load_err_event", EV_ERR);
         end
         prev_err = bus.load_err;
      end else begin
         prev_err    = 1'b0;
         chk_release = 1'b0;
      end
   end

   // reference model: parse one frame of bytes into expected writes and outcome
   task automatic model_frame();
      int i = 0;
      int n;
      logic [7:0]  sum = 8'd0;
      logic [31:0] w;
      wr_t         e;
      while (i < frm.size() && frm[i] != SYNC) i++;
      if (i + 2 >= frm.size()) return;
      n = int'({frm[i+2], frm[i+1]});
      i += 3;
      if (n == 0) begin
         exp_ev.push_back(EV_DONE);
         return;
      end
      if (n > MAX_WORDS) begin
         exp_ev.push_back(EV_ERR);
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = {frm[i+3], frm[i+2], frm[i+1], frm[i]};
         for (int j = 0; j < 4; j++) sum = sum + frm[i+j];
         e.addr = ADDR_W'(4 * k);
         e.data = w;
         exp_wr.push_back(e);
         i += 4;
      end
`ifdef LOADER_CHECKSUM_EN
      exp_ev.push_back((frm[i] == sum) ? EV_DONE : EV_ERR);
`else
      exp_ev.push_back(EV_DONE);
`endif
   endtask

   task automatic build_frame(input int lead, input int n, input logic bad_csum);
      logic [7:0]  b;
      logic [7:0]  sum = 8'd0;
      logic [31:0] w;
      frm.delete();
      repeat (lead) begin
         b = 8'($urandom);
         while (b == SYNC) b = 8'($urandom);
         frm.push_back(b);
      end
      frm.push_back(SYNC);
      frm.push_back(n[7:0]);
      frm.push_back(n[15:8]);
      if (n > 0 && n <= MAX_WORDS) begin
         for (int k = 0; k < n; k++) begin
            w = (k < wq.size()) ? wq[k] : $urandom;
            for (int j = 0; j < 4; j++) begin
               b = w[8*j +: 8];
               frm.push_back(b);
               sum = sum + b;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         frm.push_back(bad_csum ? sum + 8'd1 : sum);
`endif
      end
      if (bad_csum) wq.delete();
      wq.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL rx_ready_timeout: got rx_ready 0 for 200 cycles, expected 1");
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
   task automatic send_frame(input int mode);
      int gap;
      model_frame();
      foreach (frm[k]) begin
         gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
         send_byte(frm[k], gap);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_core_rstB"}, 64'(bus.core_rstB), 64'd0);
      check({tag, "_core_clk_en"}, 64'(bus.core_clk_en), 64'd0);
      check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd1);
      check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
      check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
      check({tag, "_mem_din"}, 64'(bus.mem_din), 64'd0);
      check({tag, "_load_done"}, 64'(bus.load_done), 64'd0);
      check({tag, "_load_err"}, 64'(bus.load_err), 64'd0);
   endtask

   initial begin
      int n;
      int lead;
      int mode;
      logic bad;
      int budget;

      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rstB = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rstB = 1'b1;
      @(posedge clk);
      #1;

      // two-word program, back-to-back
      wq = '{32'h0000_0013, 32'h0010_0093};
      build_frame(0, 2, 1'b0);
      send_frame(0);
      check("core_running_after_load", 64'(bus.core_rstB), 64'd1);

      // leading garbage and an empty frame
      frm = '{8'h55, 8'hFF, 8'hA5, 8'h00, 8'h00};
      send_frame(0);
      check("core_running_after_empty", 64'(bus.core_clk_en), 64'd1);

      // oversize count, then SYNC clears the error
      frm = '{8'hA5, 8'h01, 8'h10};
      send_frame(0);
      check("oversize_load_err", 64'(bus.load_err), 64'd1);
      check("oversize_core_held", 64'(bus.core_rstB), 64'd0);
      check("oversize_clk_held", 64'(bus.core_clk_en), 64'd0);
      frm = '{8'hA5, 8'h00, 8'h00};
      model_frame();
      send_byte(8'hA5, 0);
      check("sync_clears_load_err", 64'(bus.load_err), 64'd0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      repeat (3) @(posedge clk);
      #1;

      // same program with rx_valid toggling
      wq = '{32'h0000_0013, 32'h0010_0093};
      build_frame(0, 2, 1'b0);
      send_frame(1);

      // reset after two of four data bytes
      frm = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD};
      foreach (frm[k]) send_byte(frm[k], 0);
      @(negedge clk);
      rstB = 1'b0;
      #1;
      check_reset_values("midload_reset");
      @(negedge clk);
      rstB = 1'b1;
      @(posedge clk);
      #1;
      wq = '{32'hCAFE_0013};
      build_frame(0, 1, 1'b0);
      send_frame(0);

`ifdef LOADER_CHECKSUM_EN
      wq = '{32'h0000_0013};
      build_frame(0, 1, 1'b0);
      check("csum_byte_value", 64'(frm[frm.size()-1]), 64'h13);
      send_frame(0);
      check("csum_ok_no_err", 64'(bus.load_err), 64'd0);
      wq = '{32'h0000_0013};
      build_frame(0, 1, 1'b1);
      send_frame(0);
      check("csum_bad_load_err", 64'(bus.load_err), 64'd1);
      check("csum_bad_core_held", 64'(bus.core_rstB), 64'd0);
`endif

      // randomized frames
      for (int f = 0; f < 14; f++) begin
         lead = int'($urandom_range(0, 3));
         mode = int'($urandom_range(0, 2));
         bad  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         bad  = ($urandom_range(0, 3) == 0);
`endif
         case ($urandom_range(0, 7))
            0:       n = 0;
            1:       n = int'($urandom_range(MAX_WORDS + 1, 65535));
            default: n = int'($urandom_range(1, 6));
         endcase
         build_frame(lead, n, bad);
         send_frame(mode);
      end

      // capacity boundary: full memory, last write at 4*(MAX_WORDS-1)
      build_frame(0, MAX_WORDS, 1'b0);
      send_frame(0);

      budget = 0;
      while ((exp_wr.size() != 0 || exp_ev.size() != 0) && budget < 50) begin
         @(posedge clk);
         budget++;
      end
      check("pending_writes", 64'(exp_wr.size()), 64'd0);
      check("pending_events", 64'(exp_ev.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
